// File: rtl/nibble_mem_arbiter_if.sv
// rtl/nibble_mem_arbiter_if.sv - CPU/host request-acknowledge bus bundle for the nibble memory arbiter
interface nibble_mem_arbiter_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_hold;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic              host_halt;
  logic              host_go;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata, cpu_hold,
    input  host_req, host_we, host_addr, host_wdata, host_halt, host_go,
    output host_ack, host_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata, cpu_hold,
    output host_req, host_we, host_addr, host_wdata, host_halt, host_go,
    input  host_ack, host_rdata
  );
endinterface

// File: rtl/nibble_mem_arbiter.sv
// rtl/nibble_mem_arbiter.sv - shared 2^ADDR_W x DATA_W memory with round-robin CPU/host arbiter and boot hold
module nibble_mem_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_p,
  nibble_mem_arbiter_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic OWN_CPU  = 1'b0;
  localparam logic OWN_HOST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic              r_boot_done;
  logic              r_last_gnt;
  logic              r_gnt_owner;
  logic              r_gnt_we;
  logic [ADDR_W-1:0] r_gnt_addr;
  logic [DATA_W-1:0] r_gnt_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_cpu_ack;
  logic              r_host_ack;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_cpu_elig;
  logic              w_host_elig;
  logic              w_pick_host;
  logic              w_grant;

  // Next-state and grant decision; requests are only looked at in IDLE
  always_comb begin
    w_next      = r_state;
    w_grant     = 1'b0;
    w_cpu_elig  = bus.cpu_req & ~bus.host_halt & r_boot_done;
    w_host_elig = bus.host_req;
    // On a tie the side not served last wins
    w_pick_host = w_host_elig & (~w_cpu_elig | (r_last_gnt == OWN_CPU));
    case (r_state)
      S_IDLE: begin
        if (w_cpu_elig | w_host_elig) begin
          w_grant = 1'b1;
          w_next  = S_ACC;
        end
      end
      S_ACC:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Latch the winning request so the requester may change its inputs during the access
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_gnt_owner <= OWN_CPU;
      r_gnt_we    <= 1'b0;
      r_gnt_addr  <= '0;
      r_gnt_wdata <= '0;
    end else if (w_grant) begin
      r_gnt_owner <= w_pick_host;
      r_gnt_we    <= w_pick_host ? bus.host_we    : bus.cpu_we;
      r_gnt_addr  <= w_pick_host ? bus.host_addr  : bus.cpu_addr;
      r_gnt_wdata <= w_pick_host ? bus.host_wdata : bus.cpu_wdata;
    end
  end

  // Memory access in ACC; rdata always captures the pre-write contents, acks last one cycle
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata    <= '0;
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;
      r_last_gnt <= OWN_HOST;
    end else begin
      r_cpu_ack  <= 1'b0;
      r_host_ack <= 1'b0;
      if (r_state == S_ACC) begin
        if (r_gnt_we) r_mem[r_gnt_addr] <= r_gnt_wdata;
        r_rdata    <= r_mem[r_gnt_addr];
        r_cpu_ack  <= (r_gnt_owner == OWN_CPU);
        r_host_ack <= (r_gnt_owner == OWN_HOST);
        r_last_gnt <= r_gnt_owner;
      end
    end
  end

  // Boot release is sticky until the next reset
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p)            r_boot_done <= 1'b0;
    else if (bus.host_go) r_boot_done <= 1'b1;
  end

  assign bus.cpu_ack    = r_cpu_ack;
  assign bus.host_ack   = r_host_ack;
  assign bus.cpu_rdata  = r_rdata;
  assign bus.host_rdata = r_rdata;
  assign bus.cpu_hold   = ~r_boot_done | bus.host_halt;
endmodule

// File: tb/tb_nibble_mem_arbiter.sv
// tb/tb_nibble_mem_arbiter.sv - self-checking bench for nibble_mem_arbiter
module tb_nibble_mem_arbiter;
  localparam int AW = 6;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic rst_p;
  always #5 clk = ~clk;

  nibble_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  nibble_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_p (rst_p),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cpu_ack_cnt = 0;

  // Reference model: memory contents, last served side, and whether an ack was just seen
  logic [DW-1:0] m_mem [64];
  bit m_last_host;
  bit m_after_ack;

  always @(negedge clk) if (bus.cpu_ack === 1'b1) cpu_ack_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_last_host = 1'b1;
    m_after_ack = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    m_after_ack = 1'b0;
  endtask

  // One complete access from one side; latency is 2 from an idle arbiter, 3 right after an ack
  task automatic do_access(input bit host, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wd, input string tag);
    int lat;
    int exp_lat;
    logic got;
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_rd;
    exp_rd  = m_mem[addr];
    exp_lat = m_after_ack ? 3 : 2;
    if (host) begin
      bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wd;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      got = host ? bus.host_ack : bus.cpu_ack;
    end
    rd = host ? bus.host_rdata : bus.cpu_rdata;
    bus.host_req = 1'b0;
    bus.cpu_req  = 1'b0;
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " rdata"}, rd, exp_rd);
    if (we) m_mem[addr] = wd;
    m_last_host = host;
    m_after_ack = 1'b1;
  endtask

  initial begin
    int bad;
    int lat;
    int acks0;
    int next_ack;
    bit exp_host;
    logic [AW-1:0] ca;
    logic [AW-1:0] ha;
    logic [DW-1:0] exp_rd;

    rst_p = 1'b1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
    bus.host_halt = 0; bus.host_go = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset cpu_ack", bus.cpu_ack, 0);
    check("reset host_ack", bus.host_ack, 0);
    check("reset cpu_rdata", bus.cpu_rdata, 0);
    check("reset host_rdata", bus.host_rdata, 0);
    check("reset cpu_hold", bus.cpu_hold, 1);
    rst_p = 1'b0;

    // Boot hold: CPU request is ignored until host_go
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.cpu_hold !== 1'b1 || bus.cpu_ack !== 1'b0) bad++;
    end
    check("boot hold violations", bad, 0);
    bus.host_go = 1'b1;
    @(negedge clk);
    bus.host_go = 1'b0;
    lat = 1;
    check("hold after go", bus.cpu_hold, 0);
    while (bus.cpu_ack !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("first cpu ack latency", lat, 3);
    check("first cpu rdata", bus.cpu_rdata, 0);
    bus.cpu_req = 1'b0;
    m_last_host = 1'b0;
    m_after_ack = 1'b1;

    // Host write to top address, then read back
    do_access(1'b1, 1'b1, 6'h3F, 4'hA, "host wr 3F");
    do_access(1'b1, 1'b0, 6'h3F, 4'h0, "host rd 3F");
    check("model 3F", m_mem[63], 4'hA);

    // Both sides request continuously: alternating service, acks 3 cycles apart
    tick(1);
    ca = AW'($urandom_range(0, 63));
    ha = AW'($urandom_range(0, 63));
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = ca;
    bus.host_req = 1; bus.host_we = 0; bus.host_addr = ha;
    exp_host = !m_last_host;
    next_ack = 2;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      check($sformatf("contend c%0d cpu_ack", c), bus.cpu_ack, (c == next_ack) && !exp_host);
      check($sformatf("contend c%0d host_ack", c), bus.host_ack, (c == next_ack) && exp_host);
      if (c == next_ack) begin
        exp_rd = exp_host ? m_mem[ha] : m_mem[ca];
        check($sformatf("contend c%0d rdata", c), bus.cpu_rdata, exp_rd);
        m_last_host = exp_host;
        exp_host = !exp_host;
        next_ack += 3;
      end
    end
    bus.cpu_req = 0;
    bus.host_req = 0;
    m_after_ack = 1'b0;

    // Halt: CPU starved while host accesses run
    bus.host_halt = 1'b1;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 6'h3F;
    acks0 = cpu_ack_cnt;
    for (int k = 0; k < 7; k++) begin
      do_access(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                DW'($urandom_range(0, 15)), $sformatf("halt host %0d", k));
      bus.cpu_req = 1'b1;
      check($sformatf("halt hold %0d", k), bus.cpu_hold, 1);
    end
    check("halt cpu acks", cpu_ack_cnt - acks0, 0);
    bus.host_halt = 1'b0;
    exp_rd = m_mem[63];
    lat = 0;
    while (bus.cpu_ack !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("unhalt cpu latency", lat, 3);
    check("unhalt cpu rdata", bus.cpu_rdata, exp_rd);
    bus.cpu_req = 1'b0;
    m_last_host = 1'b0;

    // Reset in the middle of a CPU store
    tick(2);
    acks0 = cpu_ack_cnt;
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 6'h05; bus.cpu_wdata = 4'h9;
    @(negedge clk);
    rst_p = 1'b1;
    #1;
    check("midreset cpu_ack", bus.cpu_ack, 0);
    check("midreset cpu_hold", bus.cpu_hold, 1);
    @(negedge clk);
    rst_p = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    model_reset();
    tick(2);
    check("midreset no ack", cpu_ack_cnt - acks0, 0);
    check("midreset hold", bus.cpu_hold, 1);
    do_access(1'b1, 1'b0, 6'h05, 4'h0, "host rd 05 after reset");
    bus.host_go = 1'b1;
    @(negedge clk);
    bus.host_go = 1'b0;
    m_after_ack = 1'b0;

    // CPU store seen by host
    do_access(1'b0, 1'b1, 6'h10, 4'h7, "cpu wr 10");
    do_access(1'b1, 1'b0, 6'h10, 4'h0, "host rd 10");
    check("model 10", m_mem[16], 4'h7);

    // Random mixed traffic against the model
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(1, 3)));
      do_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 63)), DW'($urandom_range(0, 15)),
                $sformatf("rand %0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/nibble_mem_arbiter.md
# nibble_mem_arbiter

Shared 64 x 4-bit program/data memory with a two-port request/acknowledge arbiter, sitting between the 4-bit accumulator CPU core (fetch, load and store cycles) and a host loader port. It also sequences CPU start-up: the CPU is held after reset until the host has loaded a program and issued `host_go`. Conflicting requests are resolved round-robin, and the host can freeze the CPU at any time with `host_halt`.

## Interface
Parameters:
- `ADDR_W`, 6, address width. Memory depth is 2^ADDR_W.
- `DATA_W`, 4, word width.

Ports:
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst_p`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU access request; level, held until `cpu_ack`.
- `cpu_we`  in  1  1 = store, 0 = fetch/load.
- `cpu_addr`  in  ADDR_W  CPU word address.
- `cpu_wdata`  in  DATA_W  CPU store data.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  DATA_W  read data; valid while `cpu_ack` = 1.
- `cpu_hold`  out  1  CPU must not advance (boot not done, or halted).
- `host_req`, `host_we`, `host_addr`, `host_wdata`  in  host equivalents of the `cpu_*` inputs.
- `host_ack`, `host_rdata`  out  host equivalents of the `cpu_*` outputs.
- `host_halt`  in  1  level; while 1, CPU requests are never granted.
- `host_go`  in  1  pulse; releases the boot hold.

## Operation
- Memory: 2^ADDR_W words of DATA_W bits. All words are cleared to 0 by `rst_p`.
- FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- IDLE: sample eligible requests.
  - CPU is eligible when `cpu_req` = 1, `host_halt` = 0 and `boot_done` = 1.
  - Host is eligible when `host_req` = 1.
  - If any requester is eligible: latch the winner's `we`/`addr`/`wdata` and owner into `gnt_*`, then go to ACC.
  - Otherwise stay in IDLE.
- Tie-break is round-robin: grant the side not granted last. `last_gnt` is set to HOST at reset, so the CPU wins the first tie.
- ACC: perform the access using the latched values.
  - Write: memory[`gnt_addr`] <= `gnt_wdata`.
  - Read: `rdata` register <= memory[`gnt_addr`].
  - Always set the owner's ack register and `last_gnt` <= owner. Go to DONE.
- DONE: owner's ack is 1 for exactly this cycle; both acks clear on exit. The requester drops or changes its request in this cycle. Go to IDLE. No sampling occurs in DONE.
- Write data is not echoed: on a write ack, `rdata` holds the memory contents from before the write.
- `boot_done`: cleared by reset, set by `host_go`, never cleared except by reset.
- `cpu_hold` = !`boot_done` | `host_halt` (combinational).
- Raising `host_halt` while the CPU already owns ACC/DONE does not abort that access; it completes and is acked.
- Addresses cover the full space, so no out-of-range case exists. There is no address wrap logic; the CPU's pc wrap is its own concern.

## Timing
- Access latency: request sampled in IDLE at edge N, ACC at N+1, ack high in cycle N+2. An access occupies 3 cycles.
- Maximum throughput: one access per 3 cycles. Alternating service when both sides request continuously.
- A write is visible to any read granted after its ACC edge.
- Reset values: `cpu_ack` = `host_ack` = 0, `cpu_rdata` = `host_rdata` = 0, `cpu_hold` = 1, state = IDLE.
- `rst_p` asserted mid-access:
  - Immediately returns to IDLE and drops both acks.
  - A write not yet clocked through ACC is discarded.
  - Memory is cleared and `boot_done` = 0.
- `host_go` and `rst_p` together: reset wins.
- `host_go` in the same cycle as a CPU request: the request is not eligible until the cycle after `boot_done` sets.

## Test plan
- Reset, then CPU read request: `cpu_hold` = 1 and no `cpu_ack` for 10 cycles. Pulse `host_go`: `cpu_hold` = 0, and `cpu_ack` arrives 2 cycles after the first IDLE sample, with `cpu_rdata` = 0.
- Host writes 0xA to address 0x3F, then reads 0x3F: `host_ack` each 3rd cycle, read returns 0xA. Write ack shows the old value 0x0.
- After `host_go`, both `cpu_req` and `host_req` held high for 12 cycles: grants go CPU, HOST, CPU, HOST; acks are 3 cycles apart.
- `host_halt` = 1 with `cpu_req` = 1: `cpu_hold` = 1 and no `cpu_ack` for 20 cycles while host accesses complete. Drop halt: CPU granted within 3 cycles.
- CPU write to address 0x05 with `rst_p` pulsed during ACC: no ack, `cpu_hold` = 1, and a host read of 0x05 returns 0x0.
- CPU stores 0x7 at 0x10, then the host reads 0x10: the host read returns 0x7.
